// File: rtl/rs_alu_if.sv
// Dispatch, wakeup and issue bundle between the ALU reservation station and its neighbours.
// slave is the reservation station's view; master is the dispatch/writeback/FU side.
interface rs_alu_if #(
  parameter int DEPTH  = 8,
  parameter int PREG_W = 7,
  parameter int ROB_W  = 4,
  parameter int NWB    = 2
);
  localparam int OCC_W = $clog2(DEPTH) + 1;

  logic                  flush;
  logic                  disp_valid;
  logic [6:0]            disp_opcode;
  logic [2:0]            disp_func3;
  logic [6:0]            disp_func7;
  logic [31:0]           disp_imm;
  logic [PREG_W-1:0]     disp_ps1;
  logic [PREG_W-1:0]     disp_ps2;
  logic                  disp_ps1_rdy;
  logic                  disp_ps2_rdy;
  logic [PREG_W-1:0]     disp_pd;
  logic [ROB_W-1:0]      disp_rob;
  logic                  rs_full;
  logic [NWB-1:0]        wb_valid;
  logic [NWB*PREG_W-1:0] wb_tag;
  logic                  fu_ready;
  logic                  issued;
  logic [6:0]            iss_opcode;
  logic [2:0]            iss_func3;
  logic [6:0]            iss_func7;
  logic [31:0]           iss_imm;
  logic [PREG_W-1:0]     iss_ps1;
  logic [PREG_W-1:0]     iss_ps2;
  logic [PREG_W-1:0]     iss_pd;
  logic [ROB_W-1:0]      iss_rob;
  logic [OCC_W-1:0]      occupancy;

  modport slave (
    input  flush, disp_valid, disp_opcode, disp_func3, disp_func7, disp_imm,
           disp_ps1, disp_ps2, disp_ps1_rdy, disp_ps2_rdy, disp_pd, disp_rob,
           wb_valid, wb_tag, fu_ready,
    output rs_full, issued, iss_opcode, iss_func3, iss_func7, iss_imm,
           iss_ps1, iss_ps2, iss_pd, iss_rob, occupancy
  );

  modport master (
    output flush, disp_valid, disp_opcode, disp_func3, disp_func7, disp_imm,
           disp_ps1, disp_ps2, disp_ps1_rdy, disp_ps2_rdy, disp_pd, disp_rob,
           wb_valid, wb_tag, fu_ready,
    input  rs_full, issued, iss_opcode, iss_func3, iss_func7, iss_imm,
           iss_ps1, iss_ps2, iss_pd, iss_rob, occupancy
  );
endinterface

// File: rtl/rs_alu.sv
// Integer ALU reservation station: tag wakeup, oldest-ready select via an age matrix,
// registered single-issue output towards the PRF read ports and the ALU FU.
module rs_alu #(
  parameter int DEPTH  = 8,
  parameter int PREG_W = 7,
  parameter int ROB_W  = 4,
  parameter int NWB    = 2
) (
  input  logic clk,
  input  logic reset,
  rs_alu_if.slave bus
);
  localparam int IDX_W = $clog2(DEPTH);
  localparam int OCC_W = $clog2(DEPTH) + 1;

  typedef struct packed {
    logic [6:0]        opcode;
    logic [2:0]        func3;
    logic [6:0]        func7;
    logic [31:0]       imm;
    logic [PREG_W-1:0] ps1;
    logic [PREG_W-1:0] ps2;
    logic [PREG_W-1:0] pd;
    logic [ROB_W-1:0]  rob;
  } uop_t;

  uop_t             ent_q [DEPTH];
  uop_t             ent_d [DEPTH];
  logic [DEPTH-1:0] valid_q, valid_d;
  logic [DEPTH-1:0] rdy1_q, rdy1_d;
  logic [DEPTH-1:0] rdy2_q, rdy2_d;
  // age_q[i][j] = 1 : entry i is older than entry j
  logic [DEPTH-1:0] age_q [DEPTH];
  logic [DEPTH-1:0] age_d [DEPTH];
  logic [OCC_W-1:0] occ_q, occ_d;
  logic             issued_q, issued_d;
  uop_t             iss_q, iss_d;

  logic [DEPTH-1:0] cand, win;
  logic [IDX_W-1:0] win_idx, free_idx;
  logic             rs_full, do_iss, do_disp;
  uop_t             disp_uop;

  function automatic logic wb_hit(input logic [PREG_W-1:0]     tag,
                                  input logic [NWB-1:0]        v,
                                  input logic [NWB*PREG_W-1:0] tags);
    logic hit;
    hit = 1'b0;
    for (int k = 0; k < NWB; k++)
      if (v[k] && tags[k*PREG_W +: PREG_W] == tag) hit = 1'b1;
    return hit;
  endfunction

  assign rs_full = (occ_q == OCC_W'(DEPTH));
  assign disp_uop = '{opcode: bus.disp_opcode, func3: bus.disp_func3, func7: bus.disp_func7,
                      imm: bus.disp_imm, ps1: bus.disp_ps1, ps2: bus.disp_ps2,
                      pd: bus.disp_pd, rob: bus.disp_rob};

  // Select uses only pre-edge readiness; a winner has no older ready candidate.
  always_comb begin
    cand     = valid_q & rdy1_q & rdy2_q;
    win      = '0;
    win_idx  = '0;
    free_idx = '0;
    for (int i = 0; i < DEPTH; i++) begin
      win[i] = cand[i];
      for (int j = 0; j < DEPTH; j++)
        if (cand[j] && age_q[j][i]) win[i] = 1'b0;
    end
    for (int i = DEPTH - 1; i >= 0; i--) begin
      if (win[i])      win_idx  = IDX_W'(i);
      if (!valid_q[i]) free_idx = IDX_W'(i);
    end
  end

  assign do_iss  = bus.fu_ready && (|win);
  assign do_disp = bus.disp_valid && !rs_full;

  always_comb begin
    ent_d    = ent_q;
    age_d    = age_q;
    valid_d  = valid_q;
    rdy1_d   = rdy1_q;
    rdy2_d   = rdy2_q;
    iss_d    = iss_q;
    issued_d = 1'b0;
    occ_d    = occ_q + OCC_W'(do_disp) - OCC_W'(do_iss);

    for (int i = 0; i < DEPTH; i++) begin
      if (wb_hit(ent_q[i].ps1, bus.wb_valid, bus.wb_tag)) rdy1_d[i] = 1'b1;
      if (wb_hit(ent_q[i].ps2, bus.wb_valid, bus.wb_tag)) rdy2_d[i] = 1'b1;
    end

    if (do_iss) begin
      valid_d[win_idx] = 1'b0;
      issued_d         = 1'b1;
      iss_d            = ent_q[win_idx];
    end

    // free_idx comes from pre-edge valid, so a slot freed by issue this cycle is not reused yet
    if (do_disp) begin
      valid_d[free_idx] = 1'b1;
      ent_d[free_idx]   = disp_uop;
      rdy1_d[free_idx]  = bus.disp_ps1_rdy | wb_hit(bus.disp_ps1, bus.wb_valid, bus.wb_tag);
      rdy2_d[free_idx]  = bus.disp_ps2_rdy | wb_hit(bus.disp_ps2, bus.wb_valid, bus.wb_tag);
      age_d[free_idx]   = '0;
      for (int j = 0; j < DEPTH; j++)
        if (IDX_W'(j) != free_idx) age_d[j][free_idx] = valid_q[j];
    end

    if (bus.flush) begin
      valid_d  = '0;
      issued_d = 1'b0;
      occ_d    = '0;
      iss_d    = iss_q;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      valid_q  <= '0;
      rdy1_q   <= '0;
      rdy2_q   <= '0;
      occ_q    <= '0;
      issued_q <= 1'b0;
      iss_q    <= '0;
      for (int i = 0; i < DEPTH; i++) age_q[i] <= '0;
    end else begin
      valid_q  <= valid_d;
      rdy1_q   <= rdy1_d;
      rdy2_q   <= rdy2_d;
      occ_q    <= occ_d;
      issued_q <= issued_d;
      iss_q    <= iss_d;
      for (int i = 0; i < DEPTH; i++) begin
        age_q[i] <= age_d[i];
        ent_q[i] <= ent_d[i];
      end
    end
  end

  assign bus.rs_full    = rs_full;
  assign bus.occupancy  = occ_q;
  assign bus.issued     = issued_q;
  assign bus.iss_opcode = iss_q.opcode;
  assign bus.iss_func3  = iss_q.func3;
  assign bus.iss_func7  = iss_q.func7;
  assign bus.iss_imm    = iss_q.imm;
  assign bus.iss_ps1    = iss_q.ps1;
  assign bus.iss_ps2    = iss_q.ps2;
  assign bus.iss_pd     = iss_q.pd;
  assign bus.iss_rob    = iss_q.rob;
endmodule

// File: tb/tb_rs_alu.sv
// Directed bench for rs_alu: expected issues are queued at stimulus time and a negedge
// monitor pops and compares them whenever the RS pulses issued.
module tb_rs_alu;
  localparam int DEPTH  = 8;
  localparam int PREG_W = 7;
  localparam int ROB_W  = 4;
  localparam int NWB    = 2;

  typedef struct packed {
    logic [6:0]        opcode;
    logic [2:0]        func3;
    logic [6:0]        func7;
    logic [31:0]       imm;
    logic [PREG_W-1:0] ps1;
    logic [PREG_W-1:0] ps2;
    logic [PREG_W-1:0] pd;
    logic [ROB_W-1:0]  rob;
  } uop_t;

  logic clk = 1'b0;
  logic reset;
  int   checks = 0;
  int   errors = 0;
  uop_t exp_q [$];

  rs_alu_if #(.DEPTH(DEPTH), .PREG_W(PREG_W), .ROB_W(ROB_W), .NWB(NWB)) bus ();

  rs_alu #(.DEPTH(DEPTH), .PREG_W(PREG_W), .ROB_W(ROB_W), .NWB(NWB)) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  function automatic uop_t mk(input logic [6:0] op, input logic [2:0] f3, input logic [6:0] f7,
                              input logic [31:0] imm, input logic [6:0] ps1, input logic [6:0] ps2,
                              input logic [6:0] pd, input logic [3:0] rob);
    uop_t u;
    u = '{opcode: op, func3: f3, func7: f7, imm: imm, ps1: ps1, ps2: ps2, pd: pd, rob: rob};
    return u;
  endfunction

  task automatic send(input uop_t u, input logic r1, input logic r2);
    bus.disp_valid   = 1'b1;
    bus.disp_opcode  = u.opcode;
    bus.disp_func3   = u.func3;
    bus.disp_func7   = u.func7;
    bus.disp_imm     = u.imm;
    bus.disp_ps1     = u.ps1;
    bus.disp_ps2     = u.ps2;
    bus.disp_ps1_rdy = r1;
    bus.disp_ps2_rdy = r2;
    bus.disp_pd      = u.pd;
    bus.disp_rob     = u.rob;
  endtask

  task automatic idle();
    bus.disp_valid = 1'b0;
    bus.wb_valid   = '0;
  endtask

  always @(negedge clk) begin
    if (bus.issued === 1'b1) begin
      uop_t act, exp;
      act = '{opcode: bus.iss_opcode, func3: bus.iss_func3, func7: bus.iss_func7,
              imm: bus.iss_imm, ps1: bus.iss_ps1, ps2: bus.iss_ps2, pd: bus.iss_pd, rob: bus.iss_rob};
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_issue actual pd=%0d rob=%0d expected no issue", act.pd, act.rob);
      end else begin
        exp = exp_q.pop_front();
        if (act !== exp) begin
          errors++;
          $display("FAIL issue_fields actual=%h expected=%h (pd %0d/%0d rob %0d/%0d)",
                   act, exp, act.pd, exp.pd, act.rob, exp.rob);
        end
      end
    end
  end

  initial begin
    uop_t u;
    reset = 1'b1;
    bus.flush = 1'b0;
    bus.fu_ready = 1'b0;
    bus.wb_tag = '0;
    send(mk(0, 0, 0, 0, 0, 0, 0, 0), 1'b0, 1'b0);
    idle();
    repeat (3) step();
    chk("reset_issued", bus.issued, 0);
    chk("reset_occ", bus.occupancy, 0);
    chk("reset_full", bus.rs_full, 0);
    chk("reset_iss_pd", bus.iss_pd, 0);
    reset = 1'b0;
    step();

    // ready ADDI: write edge, then issue edge
    bus.fu_ready = 1'b1;
    u = mk(7'h13, 3'd0, 7'd0, 32'h10, 7'd5, 7'd0, 7'd9, 4'd3);
    exp_q.push_back(u);
    send(u, 1'b1, 1'b1);
    step();
    idle();
    chk("addi_occ1", bus.occupancy, 1);
    chk("addi_not_yet", bus.issued, 0);
    step();
    chk("addi_issued", bus.issued, 1);
    chk("addi_occ0", bus.occupancy, 0);
    chk("addi_pd", bus.iss_pd, 9);
    chk("addi_imm", bus.iss_imm, 32'h10);
    step();

    // age ordering: A waits on tag 7, wakes while B issues, then beats younger C
    exp_q.push_back(mk(7'h33, 3'd0, 7'd0, 32'd0, 7'd2, 7'd3, 7'd21, 4'd5));
    exp_q.push_back(mk(7'h33, 3'd0, 7'd0, 32'd0, 7'd7, 7'd1, 7'd20, 4'd4));
    exp_q.push_back(mk(7'h33, 3'd4, 7'd0, 32'd0, 7'd2, 7'd3, 7'd22, 4'd6));
    send(mk(7'h33, 3'd0, 7'd0, 32'd0, 7'd7, 7'd1, 7'd20, 4'd4), 1'b0, 1'b1);
    step();
    send(mk(7'h33, 3'd0, 7'd0, 32'd0, 7'd2, 7'd3, 7'd21, 4'd5), 1'b1, 1'b1);
    step();
    send(mk(7'h33, 3'd4, 7'd0, 32'd0, 7'd2, 7'd3, 7'd22, 4'd6), 1'b1, 1'b1);
    bus.wb_valid = 2'b01;
    bus.wb_tag   = {7'd55, 7'd7};
    step();
    idle();
    chk("age_b_issued", bus.issued, 1);
    chk("age_b_pd", bus.iss_pd, 21);
    step();
    chk("age_a_pd", bus.iss_pd, 20);
    step();
    chk("age_c_pd", bus.iss_pd, 22);
    step();
    chk("age_occ0", bus.occupancy, 0);

    // same-cycle wakeup on port 1 at dispatch
    u = mk(7'h33, 3'd0, 7'h20, 32'd0, 7'd3, 7'd12, 7'd13, 4'd7);
    exp_q.push_back(u);
    send(u, 1'b1, 1'b0);
    bus.wb_valid = 2'b10;
    bus.wb_tag   = {7'd12, 7'd0};
    step();
    idle();
    chk("swk_not_yet", bus.issued, 0);
    step();
    chk("swk_issued", bus.issued, 1);
    chk("swk_rob", bus.iss_rob, 7);

    // an unready source blocks issue until its wakeup arrives
    u = mk(7'h33, 3'd7, 7'd0, 32'd0, 7'd40, 7'd41, 7'd14, 4'd8);
    exp_q.push_back(u);
    send(u, 1'b0, 1'b1);
    step();
    idle();
    step();
    step();
    chk("wait_no_issue", bus.issued, 0);
    chk("wait_occ1", bus.occupancy, 1);
    bus.wb_valid = 2'b10;
    bus.wb_tag   = {7'd40, 7'd0};
    step();
    idle();
    chk("wake_not_yet", bus.issued, 0);
    step();
    chk("wake_issued", bus.issued, 1);
    chk("wake_occ0", bus.occupancy, 0);
    step();

    // fill to DEPTH under backpressure, drop the extra op, then drain in order
    bus.fu_ready = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      u = mk(7'h13, 3'd0, 7'd0, 32'(i), 7'd1, 7'd2, 7'(30 + i), 4'(i));
      exp_q.push_back(u);
      send(u, 1'b1, 1'b1);
      step();
      if (i == DEPTH - 2) chk("full_before_last", bus.rs_full, 0);
    end
    chk("full_occ", bus.occupancy, DEPTH);
    chk("full_flag", bus.rs_full, 1);
    send(mk(7'h13, 3'd0, 7'd0, 32'd0, 7'd1, 7'd2, 7'd99, 4'd15), 1'b1, 1'b1);
    step();
    idle();
    chk("full_drop_occ", bus.occupancy, DEPTH);
    bus.fu_ready = 1'b1;
    for (int i = 0; i < DEPTH; i++) begin
      step();
      chk("drain_issued", bus.issued, 1);
      chk("drain_pd", bus.iss_pd, 30 + i);
    end
    step();
    chk("drain_done", bus.issued, 0);
    chk("drain_occ0", bus.occupancy, 0);

    // flush overrides a pending winner and a concurrent dispatch
    bus.fu_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      send(mk(7'h13, 3'd0, 7'd0, 32'd0, 7'd1, 7'd2, 7'(60 + i), 4'(i)), 1'b1, 1'b1);
      step();
    end
    chk("pre_flush_occ", bus.occupancy, 3);
    send(mk(7'h13, 3'd0, 7'd0, 32'd0, 7'd1, 7'd2, 7'd63, 4'd3), 1'b1, 1'b1);
    bus.flush    = 1'b1;
    bus.fu_ready = 1'b1;
    step();
    bus.flush = 1'b0;
    idle();
    chk("flush_occ", bus.occupancy, 0);
    chk("flush_issued", bus.issued, 0);
    step();
    step();
    step();
    chk("post_flush_issued", bus.issued, 0);
    chk("post_flush_occ", bus.occupancy, 0);

    // reset while issued is high
    u = mk(7'h13, 3'd1, 7'd0, 32'h55, 7'd4, 7'd5, 7'd70, 4'd9);
    exp_q.push_back(u);
    send(u, 1'b1, 1'b1);
    step();
    send(mk(7'h13, 3'd0, 7'd0, 32'd1, 7'd1, 7'd2, 7'd71, 4'd10), 1'b1, 1'b1);
    step();
    chk("pre_reset_issued", bus.issued, 1);
    reset = 1'b1;
    step();
    idle();
    chk("rst_issued", bus.issued, 0);
    chk("rst_iss_pd", bus.iss_pd, 0);
    chk("rst_iss_imm", bus.iss_imm, 0);
    chk("rst_iss_rob", bus.iss_rob, 0);
    chk("rst_iss_opcode", bus.iss_opcode, 0);
    chk("rst_full", bus.rs_full, 0);
    chk("rst_occ", bus.occupancy, 0);
    reset = 1'b0;
    step();
    step();
    chk("post_rst_issued", bus.issued, 0);

    chk("scoreboard_empty", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
